// File: rtl/fw_loader_if.sv
// fw_loader_if: groups the firmware loader's control, byte-stream and
// instruction-memory signals into one bundle.
//   start        : single-cycle pulse that begins a load
//   s_valid/s_data/s_ready : byte stream valid/ready handshake
//   mem_we/mem_address/mem_data : instruction-memory word write
//   cpu_reset_n  : low holds the CPU in reset
//   done/error   : load result flags
// master modport: the side that supplies the stream and consumes results.
// slave modport : the loader itself.
interface fw_loader_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 start;
  logic                 s_valid;
  logic [7:0]           s_data;
  logic                 s_ready;
  logic                 mem_we;
  logic [CPU_WIDTH-1:0] mem_address;
  logic [CPU_WIDTH-1:0] mem_data;
  logic                 cpu_reset_n;
  logic                 done;
  logic                 error;

  modport master (
    output start, s_valid, s_data,
    input  s_ready, mem_we, mem_address, mem_data, cpu_reset_n, done, error
  );

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, mem_we, mem_address, mem_data, cpu_reset_n, done, error
  );
endinterface

// File: rtl/fw_loader.sv
// fw_loader: boot-time firmware writer for the CPU instruction memory.
// Packs an incoming byte stream little-endian into 32-bit words, writes each
// word to consecutive addresses, then compares a trailing 8-bit additive
// checksum. The CPU is released from reset only after a matching checksum.
// Ports:
//   clk       : system clock, rising edge
//   a_reset_n : asynchronous active-low reset
//   bus       : fw_loader_if.slave (start, byte stream, memory write, status)
module fw_loader #(
  parameter int                   CPU_WIDTH     = 32,
  parameter int                   FW_LENGTH     = 8,
  parameter logic [CPU_WIDTH-1:0] START_ADDRESS = 32'h0,
  parameter logic [CPU_WIDTH-1:0] CMD_WIDTH     = 32'h4
) (
  input  logic       clk,
  input  logic       a_reset_n,
  fw_loader_if.slave bus
);

  localparam int WCW = (FW_LENGTH > 1) ? $clog2(FW_LENGTH) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FW_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic                 s_ready_s;
  logic                 accept_s;
  logic                 restart_s;
  logic [1:0]           byte_cnt_r;
  logic [WCW-1:0]       word_cnt_r;
  logic [7:0]           sum_r;
  // Only the lower three bytes need holding; the fourth arrives with the write.
  logic [CPU_WIDTH-9:0] asm_r;
  logic                 mem_we_r;
  logic [CPU_WIDTH-1:0] mem_address_r;
  logic [CPU_WIDTH-1:0] mem_data_r;
  logic                 cpu_reset_n_r;
  logic                 done_r;
  logic                 error_r;

  // s_ready depends on the state register alone, never on the inputs.
  assign s_ready_s = (state_r == LOAD) || (state_r == CHECK);
  assign accept_s  = bus.s_valid && s_ready_s;
  assign restart_s = bus.start && ((state_r == IDLE) || (state_r == ERROR));

  assign bus.s_ready     = s_ready_s;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_address = mem_address_r;
  assign bus.mem_data    = mem_data_r;
  assign bus.cpu_reset_n = cpu_reset_n_r;
  assign bus.done        = done_r;
  assign bus.error       = error_r;

  // State register.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = LOAD;
        else           state_next_s = IDLE;
      end
      LOAD: begin
        if (accept_s && (byte_cnt_r == 2'd3)) state_next_s = WRITE;
        else                                  state_next_s = LOAD;
      end
      WRITE: begin
        if (word_cnt_r == LAST_WORD) state_next_s = CHECK;
        else                         state_next_s = LOAD;
      end
      CHECK: begin
        if (accept_s) begin
          if (bus.s_data == sum_r) state_next_s = DONE;
          else                     state_next_s = ERROR;
        end else begin
          state_next_s = CHECK;
        end
      end
      DONE: state_next_s = DONE;
      ERROR: begin
        if (bus.start) state_next_s = LOAD;
        else           state_next_s = ERROR;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Counters, checksum, word assembly and the memory write port.
  // The word and its address are captured on the 4th byte so that they are
  // already stable in the WRITE cycle.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      byte_cnt_r    <= 2'd0;
      word_cnt_r    <= '0;
      sum_r         <= 8'd0;
      asm_r         <= '0;
      mem_address_r <= '0;
      mem_data_r    <= '0;
    end else if (restart_s) begin
      byte_cnt_r <= 2'd0;
      word_cnt_r <= '0;
      sum_r      <= 8'd0;
    end else if ((state_r == LOAD) && accept_s) begin
      sum_r      <= sum_r + bus.s_data;
      byte_cnt_r <= byte_cnt_r + 2'd1;
      if (byte_cnt_r == 2'd3) begin
        mem_data_r    <= {bus.s_data, asm_r};
        mem_address_r <= START_ADDRESS + CMD_WIDTH * CPU_WIDTH'(word_cnt_r);
      end else begin
        asm_r[{byte_cnt_r, 3'b000} +: 8] <= bus.s_data;
      end
    end else if ((state_r == WRITE) && (word_cnt_r != LAST_WORD)) begin
      word_cnt_r <= word_cnt_r + 1'b1;
    end
  end

  // Status outputs registered from the state being entered, so each one
  // lines up exactly with its state.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      mem_we_r      <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      cpu_reset_n_r <= 1'b0;
    end else begin
      mem_we_r      <= (state_next_s == WRITE);
      done_r        <= (state_next_s == DONE);
      error_r       <= (state_next_s == ERROR);
      cpu_reset_n_r <= (state_next_s == DONE);
    end
  end

endmodule

// File: tb/tb_fw_loader.sv
// tb_fw_loader: self-checking bench for fw_loader with FW_LENGTH=2.
// A table of images drives whole loads; expected writes go into a scoreboard
// queue when the last byte of each word is driven and are popped by a monitor
// on every mem_we pulse. Hand-written sequences cover the retry after a bad
// checksum and reset in the middle of a load.
module tb_fw_loader;
  localparam int FWL = 2;

  logic clk = 1'b0;
  logic a_reset_n = 1'b0;

  fw_loader_if #(.CPU_WIDTH(32)) bus();

  fw_loader #(
    .CPU_WIDTH(32), .FW_LENGTH(FWL), .START_ADDRESS(32'h0), .CMD_WIDTH(32'h4)
  ) dut (
    .clk(clk), .a_reset_n(a_reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] img;       // byte 0 in bits [7:0]
    logic [7:0]  ck_delta;  // added to the true checksum
    bit          gaps;      // random idle cycles on s_valid
    bit          start_mid; // pulse start while loading
    bit          exp_done;
    bit          exp_error;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   start_cyc = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: each mem_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    if (bus.mem_we === 1'b1) begin
      we_count++;
      if (prev_we === 1'b1) chk("we_pulse_width", {31'b0, prev_we}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", {31'b0, bus.mem_we}, 32'd0);
      end else begin
        w = sb.pop_front();
        chk("wr_addr", bus.mem_address, w.addr);
        chk("wr_data", bus.mem_data, w.data);
      end
    end
    prev_we = bus.mem_we;
  end

  function automatic logic [7:0] sum8(input logic [63:0] img);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 8; i++) s = s + img[8*i +: 8];
    return s;
  endfunction

  task automatic do_reset();
    a_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    bit got = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    bus.start   = with_start;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    if (!got) chk("handshake_timeout", {31'b0, bus.s_ready}, 32'd1);
  endtask

  // Streams 8 image bytes plus the checksum, queueing each expected write.
  task automatic send_image(input logic [63:0] img, input logic [7:0] ck,
                            input bit gaps, input bit start_mid);
    wr_t w;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) begin
        w.addr = 32'(4 * (i / 4));
        w.data = img[32*(i/4) +: 32];
        sb.push_back(w);
      end
      send_byte(img[8*i +: 8], gaps, start_mid && (i == 2));
    end
    send_byte(ck, gaps, 1'b0);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_idle_outputs();
    chk("idle_s_ready", {31'b0, bus.s_ready}, 32'd0);
    chk("idle_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("idle_done", {31'b0, bus.done}, 32'd0);
    chk("idle_error", {31'b0, bus.error}, 32'd0);
    chk("idle_cpu_reset_n", {31'b0, bus.cpu_reset_n}, 32'd0);
    chk("idle_mem_address", bus.mem_address, 32'd0);
    chk("idle_mem_data", bus.mem_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we0;
    logic [63:0] img1;
    logic [63:0] img_ff;
    img1   = 64'h00200593_00100513;
    img_ff = 64'hFFFFFFFF_FFFFFFFF;

    vecs[0] = '{img1,   8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{img1,   8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{img1,   8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{img_ff, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{img_ff, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'h08070605_04030201, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state.
    #12;
    check_idle_outputs();
    do_reset();
    check_idle_outputs();

    // Table-driven loads.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      we0 = we_count;
      pulse_start();
      send_image(vecs[v].img, sum8(vecs[v].img) + vecs[v].ck_delta,
                 vecs[v].gaps, vecs[v].start_mid);
      chk("vec_done", {31'b0, bus.done}, {31'b0, vecs[v].exp_done});
      chk("vec_error", {31'b0, bus.error}, {31'b0, vecs[v].exp_error});
      chk("vec_cpu_reset_n", {31'b0, bus.cpu_reset_n}, {31'b0, vecs[v].exp_done});
      chk("vec_s_ready", {31'b0, bus.s_ready}, 32'd0);
      if (!vecs[v].gaps) chk("vec_latency", 32'(cyc - start_cyc), 32'(5 * FWL + 1));
      chk("vec_write_count", 32'(we_count - we0), 32'(FWL));
      chk("vec_queue_empty", 32'(sb.size()), 32'd0);
      if (vecs[v].exp_done) begin
        // start must not disturb the terminal state.
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", {31'b0, bus.done}, 32'd1);
        chk("done_hold_cpu", {31'b0, bus.cpu_reset_n}, 32'd1);
        chk("done_hold_ready", {31'b0, bus.s_ready}, 32'd0);
        chk("done_hold_writes", 32'(we_count - we0), 32'(FWL));
      end
    end

    // Bad checksum, then retry from ERROR without reset.
    do_reset();
    pulse_start();
    send_image(img1, 8'hE1, 1'b0, 1'b0);
    chk("retry_error", {31'b0, bus.error}, 32'd1);
    chk("retry_cpu_held", {31'b0, bus.cpu_reset_n}, 32'd0);
    pulse_start();
    chk("retry_error_cleared", {31'b0, bus.error}, 32'd0);
    chk("retry_s_ready", {31'b0, bus.s_ready}, 32'd1);
    we0 = we_count;
    send_image(img1, 8'hE0, 1'b0, 1'b0);
    chk("retry_done", {31'b0, bus.done}, 32'd1);
    chk("retry_cpu_reset_n", {31'b0, bus.cpu_reset_n}, 32'd1);
    chk("retry_writes", 32'(we_count - we0), 32'd2);

    // Reset after 5 accepted bytes.
    do_reset();
    pulse_start();
    begin
      wr_t w;
      w.addr = 32'h0;
      w.data = img1[31:0];
      sb.push_back(w);
    end
    for (int i = 0; i < 5; i++) send_byte(img1[8*i +: 8], 1'b0, 1'b0);
    bus.s_valid = 1'b0;
    chk("midrst_word0_written", 32'(sb.size()), 32'd0);
    a_reset_n = 1'b0;
    #1;
    check_idle_outputs();
    @(posedge clk);
    #1 a_reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_stays_idle", {31'b0, bus.s_ready}, 32'd0);
    we0 = we_count;
    pulse_start();
    send_image(img1, 8'hE0, 1'b0, 1'b0);
    chk("midrst_done", {31'b0, bus.done}, 32'd1);
    chk("midrst_writes", 32'(we_count - we0), 32'd2);
    chk("midrst_queue_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fw_loader.md
Name: fw_loader

Overview:
- Boot-time firmware writer for the instruction memory that the CPU fetches from.
- Accepts a byte stream over a valid/ready interface and packs it little-endian into CPU_WIDTH-bit words.
- Writes each word to consecutive instruction addresses, then checks a trailing 8-bit additive checksum.
- Holds the CPU in reset until the load completes with a correct checksum.

Parameters:
- CPU_WIDTH, 32, data word width; fixed at 32 (4 bytes per word).
- FW_LENGTH, 8, number of words per image.
- START_ADDRESS, 32'h0, byte address of the first word.
- CMD_WIDTH, 32'h4, address increment per word.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- a_reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; begins a load from IDLE or ERROR.
- s_valid  input  1  byte stream valid.
- s_data  input  8  byte stream data.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_address  output  CPU_WIDTH  byte address of the word being written.
- mem_data  output  CPU_WIDTH  packed word.
- cpu_reset_n  output  1  low holds the CPU in reset; high only in DONE.
- done  output  1  image loaded and checksum matched.
- error  output  1  checksum mismatch.

Behaviour:
- Reset (async, a_reset_n=0): state=IDLE; all outputs 0, including cpu_reset_n; byte_cnt, word_cnt, sum and the assembly register cleared.
- Handshake: a byte is consumed only in a cycle with s_valid && s_ready. s_valid with s_ready=0 consumes nothing; the source must hold the byte.
- FSM states: IDLE, LOAD, WRITE, CHECK, DONE, ERROR.
- IDLE: s_ready=0. start=1 -> LOAD; clears byte_cnt, word_cnt and sum.
- LOAD: s_ready=1. Each accepted byte:
  - stored at bits [8*byte_cnt+7 : 8*byte_cnt];
  - sum <= sum + s_data, mod 256;
  - byte_cnt increments, wrapping 3 -> 0.
  - Accepting the byte with byte_cnt=3 -> WRITE.
- WRITE: exactly one cycle.
  - mem_we=1; mem_data=assembled word; mem_address=START_ADDRESS + CMD_WIDTH*word_cnt; s_ready=0.
  - If word_cnt==FW_LENGTH-1 -> CHECK; otherwise word_cnt+1 and -> LOAD.
  - Latency: mem_we asserts in the cycle after the 4th byte's handshake.
- mem_we is 0 in every state except WRITE. mem_address and mem_data hold their last values outside WRITE.
- CHECK: s_ready=1. The first accepted byte is compared with sum:
  - equal -> DONE;
  - unequal -> ERROR.
  - This byte is not added to sum and is not written to memory.
- DONE: done=1, cpu_reset_n=1, s_ready=0. Terminal state; start is ignored. Only a_reset_n leaves DONE.
- ERROR: error=1, cpu_reset_n=0, s_ready=0. start -> LOAD, which clears error, counters and sum in the same edge.
- start is ignored in LOAD, WRITE, CHECK and DONE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Words already written remain in memory; the CPU stays held in reset.
- Only registered outputs, no combinational path from the inputs. Exception: s_ready is decoded from the state register only.
- Total load with no stalls: 5*FW_LENGTH + 1 cycles after the start edge.

Test Plan:
- FW_LENGTH=2; stream 13 05 10 00 93 05 20 00, then checksum E0 -> two writes: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593; done=1, cpu_reset_n=1, error=0.
- Same image with checksum E1 -> error=1, done=0, cpu_reset_n=0. Then pulse start and send the correct stream -> done=1, writes repeated at 0x0/0x4.
- Backpressure: randomly drop s_valid, and hold s_valid high through each WRITE cycle (s_ready=0) -> no byte lost or duplicated; same writes as scenario 1; exactly one mem_we pulse per word.
- Checksum wrap: FW_LENGTH=2, eight bytes of FF (sum 0x7F8), checksum F8 -> done=1; both writes data 0xFFFFFFFF.
- Assert a_reset_n=0 after 5 accepted bytes -> outputs 0 immediately, state IDLE. Release, start, full stream -> correct writes and done=1.
- start pulses during LOAD and during DONE -> no effect on counters, writes, done or cpu_reset_n.
